// File: rtl/go_pkg.sv
// Shared Go-board types and constants for the move entry block.
package go_pkg;

  localparam int BOARD_SIZE = 9;

  typedef logic [1:0] cell_t;

  localparam cell_t CELL_EMPTY = 2'b00;
  localparam cell_t CELL_BLACK = 2'b01;
  localparam cell_t CELL_WHITE = 2'b10;

  localparam logic [7:0] MOVE_PASS = 8'hFF;

  // board[row][col], each point a 2-bit cell code
  typedef cell_t [BOARD_SIZE-1:0][BOARD_SIZE-1:0] board_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    REJECT = 2'd2,
    OFFER  = 2'd3
  } state_t;

  // Cursor step towards zero, wrapping 0 -> BOARD_SIZE-1
  function automatic logic [3:0] wrap_dec(input logic [3:0] v);
    return (v == 4'd0) ? 4'(BOARD_SIZE - 1) : v - 4'd1;
  endfunction

  // Cursor step away from zero, wrapping BOARD_SIZE-1 -> 0
  function automatic logic [3:0] wrap_inc(input logic [3:0] v);
    return (v == 4'(BOARD_SIZE - 1)) ? 4'd0 : v + 4'd1;
  endfunction

endpackage

// File: rtl/move_entry_fsm_btn_edge.sv
// btn_edge: registers one debounced button and emits a one-cycle press pulse.
// A button already held when reset releases must be let go before it can
// press. With MOVE_ENTRY_AUTO_REPEAT_EN defined and REPEAT_EN set, a held
// button re-fires every REPEAT_CYCLES cycles until released or cleared.
module btn_edge
`ifdef MOVE_ENTRY_AUTO_REPEAT_EN
  #(
    parameter bit          REPEAT_EN     = 1'b0,
    parameter int unsigned REPEAT_CYCLES = 16_250_000
  )
`endif
  (
    input  logic clk_in,
    input  logic reset,
    input  logic btn,
`ifdef MOVE_ENTRY_AUTO_REPEAT_EN
    input  logic hold_clr,
`endif
    output logic press
  );

  logic btn_q;
  logic prev_q;
  logic arm_q;
  logic edge_p;

  // Button history plus an arm flag that only sets once the raw button is seen low
  always_ff @(posedge clk_in) begin
    if (reset) begin
      btn_q  <= 1'b0;
      prev_q <= 1'b0;
      arm_q  <= 1'b0;
    end else begin
      btn_q  <= btn;
      prev_q <= btn_q;
      arm_q  <= arm_q | ~btn;
    end
  end

  assign edge_p = btn_q & ~prev_q & arm_q;

`ifdef MOVE_ENTRY_AUTO_REPEAT_EN
  if (REPEAT_EN) begin : g_rep
    localparam int CW = $clog2(REPEAT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          rep_p;

    // Hold counter: restarts on the initial press, on release and on clear
    always_comb begin
      cnt_d = cnt_q;
      rep_p = 1'b0;
      if (hold_clr || !btn_q || edge_p) begin
        cnt_d = '0;
      end else if (prev_q && arm_q) begin
        if (cnt_q == CW'(REPEAT_CYCLES - 1)) begin
          rep_p = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Hold counter register
    always_ff @(posedge clk_in) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign press = edge_p | rep_p;
  end else begin : g_norep
    assign press = edge_p;
  end
`else
  assign press = edge_p;
`endif

endmodule

// File: rtl/move_entry_fsm.sv
// move_entry_fsm: turns button presses into a cursor on the 9x9 board and
// offers occupancy-checked moves (or passes) over a valid/ack handshake.
// Optional macro MOVE_ENTRY_AUTO_REPEAT_EN enables held-direction auto-repeat.
module move_entry_fsm
  import go_pkg::*;
`ifdef MOVE_ENTRY_AUTO_REPEAT_EN
  #(
    parameter int unsigned REPEAT_CYCLES = 16_250_000
  )
`endif
  (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_place,
    input  logic        btn_pass,
    input  board_t      board,
    input  logic        move_ack,
    output logic [7:0]  move,
    output logic        move_avail,
    output logic [1:0]  turn,
    output logic [3:0]  cursor_row,
    output logic [3:0]  cursor_col,
    output logic        reject
  );

  // Direction index: 0 up, 1 down, 2 left, 3 right (also the priority order)
  logic [3:0] dir_btn;
  logic [3:0] dir_press;
  logic       place_p;
  logic       pass_p;

  assign dir_btn = {btn_right, btn_left, btn_down, btn_up};

`ifdef MOVE_ENTRY_AUTO_REPEAT_EN
  logic [3:0] dir_clr;
`endif

  state_t     state_q, state_d;
  logic [7:0] move_q, move_d;
  cell_t      turn_q, turn_d;
  logic [3:0] row_q, row_d;
  logic [3:0] col_q, col_d;
  logic [3:0] lat_row_q, lat_row_d;
  logic [3:0] lat_col_q, lat_col_d;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_dir
`ifdef MOVE_ENTRY_AUTO_REPEAT_EN
    // Repeat restarts when leaving IDLE or when any other direction is held
    assign dir_clr[gi] = (state_q != IDLE) || ((dir_btn & ~(4'd1 << gi)) != 4'd0);

    btn_edge #(
      .REPEAT_EN     (1'b1),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_edge (
      .clk_in   (clk_in),
      .reset    (reset),
      .btn      (dir_btn[gi]),
      .hold_clr (dir_clr[gi]),
      .press    (dir_press[gi])
    );
`else
    btn_edge u_edge (
      .clk_in (clk_in),
      .reset  (reset),
      .btn    (dir_btn[gi]),
      .press  (dir_press[gi])
    );
`endif
  end

`ifdef MOVE_ENTRY_AUTO_REPEAT_EN
  btn_edge #(.REPEAT_EN(1'b0), .REPEAT_CYCLES(REPEAT_CYCLES)) u_place (
    .clk_in (clk_in), .reset (reset), .btn (btn_place), .hold_clr (1'b0), .press (place_p)
  );
  btn_edge #(.REPEAT_EN(1'b0), .REPEAT_CYCLES(REPEAT_CYCLES)) u_pass (
    .clk_in (clk_in), .reset (reset), .btn (btn_pass), .hold_clr (1'b0), .press (pass_p)
  );
`else
  btn_edge u_place (
    .clk_in (clk_in), .reset (reset), .btn (btn_place), .press (place_p)
  );
  btn_edge u_pass (
    .clk_in (clk_in), .reset (reset), .btn (btn_pass), .press (pass_p)
  );
`endif

  // Next-state logic: cursor stepping, place/pass capture, occupancy check, handshake
  always_comb begin
    state_d   = state_q;
    move_d    = move_q;
    turn_d    = turn_q;
    row_d     = row_q;
    col_d     = col_q;
    lat_row_d = lat_row_q;
    lat_col_d = lat_col_q;
    unique case (state_q)
      IDLE: begin
        if (place_p) begin
          state_d   = CHECK;
          lat_row_d = row_q;
          lat_col_d = col_q;
        end else if (pass_p) begin
          state_d = OFFER;
          move_d  = MOVE_PASS;
        end else if (dir_press[0]) begin
          row_d = wrap_dec(row_q);
        end else if (dir_press[1]) begin
          row_d = wrap_inc(row_q);
        end else if (dir_press[2]) begin
          col_d = wrap_dec(col_q);
        end else if (dir_press[3]) begin
          col_d = wrap_inc(col_q);
        end
      end
      CHECK: begin
        if (board[lat_row_q][lat_col_q] == CELL_EMPTY) begin
          state_d = OFFER;
          move_d  = {lat_row_q, lat_col_q};
        end else begin
          state_d = REJECT;
        end
      end
      REJECT: begin
        state_d = IDLE;
      end
      OFFER: begin
        if (move_ack) begin
          state_d = IDLE;
          turn_d  = (turn_q == CELL_BLACK) ? CELL_WHITE : CELL_BLACK;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, move, turn and cursor registers
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q   <= IDLE;
      move_q    <= 8'h00;
      turn_q    <= CELL_BLACK;
      row_q     <= 4'd4;
      col_q     <= 4'd4;
      lat_row_q <= 4'd0;
      lat_col_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      move_q    <= move_d;
      turn_q    <= turn_d;
      row_q     <= row_d;
      col_q     <= col_d;
      lat_row_q <= lat_row_d;
      lat_col_q <= lat_col_d;
    end
  end

  assign move       = move_q;
  assign move_avail = (state_q == OFFER);
  assign reject     = (state_q == REJECT);
  assign turn       = turn_q;
  assign cursor_row = row_q;
  assign cursor_col = col_q;

endmodule
